// File: rtl/systolic_matmul_engine_if.sv
// Streaming bundle for systolic_matmul_engine: job control, operand beats in, result rows out.
// The master drives the job and operands; the slave is the engine.
interface systolic_matmul_engine_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W    = 8,
  parameter int ACCW = 32,
  parameter int KW   = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                   start;
  logic [KW-1:0]          k_len;
  logic                   relu_en;
  logic                   sat_en;
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*W-1:0]      a_col;
  logic [COLS*W-1:0]      b_row;
  logic                   out_valid;
  logic                   out_ready;
  logic [COLS*ACCW-1:0]   out_row;
  logic [RW-1:0]          out_row_idx;
  logic                   busy;
  logic                   done;
  logic                   ovf;

  modport master (
    output start, k_len, relu_en, sat_en, in_valid, a_col, b_row, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, busy, done, ovf
  );

  modport slave (
    input  start, k_len, relu_en, sat_en, in_valid, a_col, b_row, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, busy, done, ovf
  );
endinterface

// File: rtl/systolic_matmul_engine.sv
// Output-stationary ROWS x COLS systolic matmul: skewed operand injection, registered PE
// forwarding, saturating/wrapping accumulation, and a row-by-row result drain with optional ReLU.
module systolic_matmul_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int W    = 8,
  parameter int ACCW = 32,
  parameter int KW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  systolic_matmul_engine_if.slave   io
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic signed [ACCW-1:0] ACC_MAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] ACC_MIN = {1'b1, {(ACCW-1){1'b0}}};

  logic [2:0]            state_reg, state_next;
  logic [KW-1:0]         k_len_reg, beat_cnt_reg;
  logic [FW-1:0]         flush_cnt_reg;
  logic                  relu_reg, sat_reg, ovf_reg, out_valid_reg;
  logic [RW-1:0]         row_reg, load_row;
  logic [COLS*ACCW-1:0]  out_row_reg, row_data;
  logic                  clr, beat, adv, pop, last_row;

  logic signed [W-1:0]    a_edge [ROWS];
  logic signed [W-1:0]    b_edge [COLS];
  logic signed [W-1:0]    a_q    [ROWS][COLS];
  logic signed [W-1:0]    b_q    [ROWS][COLS];
  logic signed [ACCW-1:0] acc    [ROWS][COLS];
  logic [ROWS*COLS-1:0]   pe_ovf;

  assign clr      = (state_reg == S_IDLE) && io.start;
  assign beat     = (state_reg == S_LOAD) && io.in_valid;
  assign adv      = beat || (state_reg == S_FLUSH);
  assign pop      = out_valid_reg && io.out_ready;
  assign last_row = (row_reg == RW'(ROWS - 1));
  assign load_row = out_valid_reg ? row_reg + 1'b1 : row_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (io.start) state_next = (io.k_len == '0) ? S_FLUSH : S_LOAD;
      S_LOAD:  if (beat && (beat_cnt_reg == k_len_reg - 1'b1)) state_next = S_FLUSH;
      S_FLUSH: if (flush_cnt_reg == FW'(ROWS + COLS - 2)) state_next = S_DRAIN;
      S_DRAIN: if (pop && last_row) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      k_len_reg     <= '0;
      beat_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      relu_reg      <= 1'b0;
      sat_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      row_reg       <= '0;
      out_row_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (clr) begin
        k_len_reg     <= io.k_len;
        relu_reg      <= io.relu_en;
        sat_reg       <= io.sat_en;
        ovf_reg       <= 1'b0;
        beat_cnt_reg  <= '0;
        flush_cnt_reg <= '0;
      end else if (adv && (|pe_ovf)) begin
        ovf_reg <= 1'b1;
      end
      if (beat) beat_cnt_reg <= beat_cnt_reg + 1'b1;
      if (state_reg == S_FLUSH) flush_cnt_reg <= flush_cnt_reg + 1'b1;
      // First DRAIN cycle preloads row 0, so the output row is always a registered copy.
      if (state_reg == S_DRAIN) begin
        if (!out_valid_reg || (pop && !last_row)) begin
          out_row_reg   <= row_data;
          out_valid_reg <= 1'b1;
          row_reg       <= load_row;
        end else if (pop) begin
          out_valid_reg <= 1'b0;
          row_reg       <= '0;
        end
      end
    end
  end

  always_comb begin
    row_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (load_row == RW'(r)) begin
        for (int c = 0; c < COLS; c++) begin
          row_data[c*ACCW +: ACCW] = (relu_reg && acc[r][c][ACCW-1]) ? '0 : acc[r][c];
        end
      end
    end
  end

  // Row i of A / column j of B is delayed i / j advances so operands meet at the right PE.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
    logic signed [W-1:0] a_in;
    assign a_in = (state_reg == S_LOAD) ? io.a_col[gi*W +: W] : '0;
    if (gi == 0) begin : g_direct
      assign a_edge[gi] = a_in;
    end else begin : g_chain
      logic signed [W-1:0] sh [gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int n = 0; n < gi; n++) sh[n] <= '0;
        end else if (adv) begin
          sh[0] <= a_in;
          for (int n = 1; n < gi; n++) sh[n] <= sh[n-1];
        end
      end
      assign a_edge[gi] = sh[gi-1];
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_b_skew
    logic signed [W-1:0] b_in;
    assign b_in = (state_reg == S_LOAD) ? io.b_row[gi*W +: W] : '0;
    if (gi == 0) begin : g_direct
      assign b_edge[gi] = b_in;
    end else begin : g_chain
      logic signed [W-1:0] sh [gi];
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          for (int n = 0; n < gi; n++) sh[n] <= '0;
        end else if (adv) begin
          sh[0] <= b_in;
          for (int n = 1; n < gi; n++) sh[n] <= sh[n-1];
        end
      end
      assign b_edge[gi] = sh[gi-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      logic signed [W-1:0]    a_in, b_in;
      logic signed [2*W-1:0]  prod;
      logic signed [ACCW-1:0] prod_x, sum;
      logic                   of;

      if (gj == 0) begin : g_a_src
        assign a_in = a_edge[gi];
      end else begin : g_a_fwd
        assign a_in = a_q[gi][gj-1];
      end
      if (gi == 0) begin : g_b_src
        assign b_in = b_edge[gj];
      end else begin : g_b_fwd
        assign b_in = b_q[gi-1][gj];
      end

      assign prod   = a_in * b_in;
      assign prod_x = ACCW'(prod);
      assign sum    = acc[gi][gj] + prod_x;
      assign of     = (acc[gi][gj][ACCW-1] == prod_x[ACCW-1]) &&
                      (sum[ACCW-1] != acc[gi][gj][ACCW-1]);
      assign pe_ovf[gi*COLS + gj] = of;

      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          a_q[gi][gj] <= '0;
          b_q[gi][gj] <= '0;
          acc[gi][gj] <= '0;
        end else if (adv) begin
          a_q[gi][gj] <= a_in;
          b_q[gi][gj] <= b_in;
          if (of && sat_reg) acc[gi][gj] <= acc[gi][gj][ACCW-1] ? ACC_MIN : ACC_MAX;
          else               acc[gi][gj] <= sum;
        end
      end
    end
  end

  assign io.in_ready    = (state_reg == S_LOAD);
  assign io.out_valid   = out_valid_reg;
  assign io.out_row     = out_row_reg;
  assign io.out_row_idx = row_reg;
  assign io.busy        = (state_reg != S_IDLE);
  assign io.done        = (state_reg == S_DONE);
  assign io.ovf         = ovf_reg;
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboard bench for systolic_matmul_engine (4x4, 16-bit accumulators).
module tb_systolic_matmul_engine;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int W    = 8;
  localparam int ACCW = 16;
  localparam int KW   = 8;
  localparam int KMAX = 8;
  localparam longint MAXV = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACCW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  int A [ROWS][KMAX];
  int B [KMAX][COLS];
  logic [COLS*ACCW-1:0] exp_rows [ROWS];
  logic                 exp_ovf;
  logic [COLS*ACCW-1:0] row_q [$];
  int                   idx_q [$];

  systolic_matmul_engine_if #(.ROWS(ROWS), .COLS(COLS), .W(W), .ACCW(ACCW), .KW(KW)) bus ();

  systolic_matmul_engine #(.ROWS(ROWS), .COLS(COLS), .W(W), .ACCW(ACCW), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: sequential k-order accumulation with per-step clamp or wrap.
  task automatic model(input int k, input bit relu, input bit sat);
    longint a, s;
    logic signed [ACCW-1:0] t;
    exp_ovf = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        a = 0;
        for (int kk = 0; kk < k; kk++) begin
          s = a + longint'(A[i][kk]) * longint'(B[kk][j]);
          if (s > MAXV || s < MINV) begin
            exp_ovf = 1'b1;
            if (sat) s = (s > 0) ? MAXV : MINV;
            else begin t = s[ACCW-1:0]; s = longint'(t); end
          end
          a = s;
        end
        if (relu && a < 0) a = 0;
        exp_rows[i][j*ACCW +: ACCW] = a[ACCW-1:0];
      end
    end
  endtask

  task automatic run_job(input int k, input bit relu, input bit sat, input int bubble_pct,
                         input bit stall, input bit poke);
    int sent, lat_base, n, d0;
    model(k, relu, sat);
    for (int r = 0; r < ROWS; r++) begin
      row_q.push_back(exp_rows[r]);
      idx_q.push_back(r);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    if (stall) bus.out_ready = 1'b0;
    bus.start = 1'b1; bus.k_len = KW'(k); bus.relu_en = relu; bus.sat_en = sat;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    sent = 0; lat_base = 0; n = 0;
    while (sent < k && n < 1000) begin
      bus.in_valid = (int'($urandom_range(99)) >= bubble_pct);
      for (int i = 0; i < ROWS; i++) bus.a_col[i*W +: W] = A[i][sent][W-1:0];
      for (int j = 0; j < COLS; j++) bus.b_row[j*W +: W] = B[sent][j][W-1:0];
      // A start while LOAD must be ignored, including its new mode bits.
      bus.start   = poke && (sent == 2);
      bus.k_len   = (poke && sent == 2) ? '0 : KW'(k);
      bus.relu_en = (poke && sent == 2) ? ~relu : relu;
      bus.sat_en  = (poke && sent == 2) ? ~sat : sat;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin sent++; lat_base = cyc; end
      n++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.start = 1'b0;
    bus.k_len = KW'(k); bus.relu_en = relu; bus.sat_en = sat;
    check("beats_sent", sent, k);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 100);
    check("out_valid_seen", bus.out_valid, 1);
    if (k > 0) check("latency", cyc - lat_base, ROWS + COLS + 1);
    if (stall) begin
      for (int s = 0; s < 5; s++) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_idx", bus.out_row_idx, 0);
        @(negedge clk);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
    end
    n = 0;
    while (!bus.done && n < 200) begin @(negedge clk); n++; end
    check("done_seen", bus.done, 1);
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("ovf", bus.ovf, exp_ovf);
    check("idle_after", bus.busy, 0);
    check("queue_drained", row_q.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every accepted row and checks hold stability.
  initial begin
    logic                 hold_prev;
    logic [COLS*ACCW-1:0] prev_row, e;
    int                   prev_idx, ei;
    hold_prev = 1'b0; prev_row = '0; prev_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && bus.out_valid) begin
          check("hold_row", bus.out_row, prev_row);
          check("hold_idx", bus.out_row_idx, prev_idx);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (row_q.size() == 0) begin
            check("unexpected_row", row_q.size(), 1);
          end else begin
            e  = row_q.pop_front();
            ei = idx_q.pop_front();
            $display("row idx=%0d data=%h expected=%h", bus.out_row_idx, bus.out_row, e);
            check("row_data", bus.out_row, e);
            check("row_idx", bus.out_row_idx, ei);
          end
        end
        if (bus.done) done_cnt++;
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_row  = bus.out_row;
        prev_idx  = int'(bus.out_row_idx);
      end
    end
  end

  task automatic set_const(input int av, input int bv);
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) A[i][k] = av;
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) B[k][j] = bv;
  endtask

  task automatic set_random();
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) A[i][k] = int'($urandom_range(60)) - 30;
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) B[k][j] = int'($urandom_range(60)) - 30;
  endtask

  initial begin
    bus.start = 1'b0; bus.k_len = '0; bus.relu_en = 1'b0; bus.sat_en = 1'b0;
    bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity A, ramp B; a start pulse mid-LOAD must not disturb the job.
    for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) A[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) B[k][j] = 4 * k + j;
    run_job(4, 1'b0, 1'b1, 0, 1'b0, 1'b1);

    set_random();
    run_job(8, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_job(8, 1'b0, 1'b1, 40, 1'b0, 1'b0);

    set_const(127, 127);
    run_job(3, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_job(3, 1'b0, 1'b0, 20, 1'b0, 1'b0);

    set_const(-1, 1);
    run_job(3, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_job(3, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_job(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of LOAD abandons the job with no output.
    set_random();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.k_len = 8'd8;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_load_ready", bus.in_ready, 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_row", bus.out_row, 0);
    check("midrst_idx", bus.out_row_idx, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_ovf", bus.ovf, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_job(5, 1'b1, 1'b1, 30, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
